// File: rtl/lieat_ifu_bpubht_pkg.sv
// Shared types and defaults for the IFU branch-history-table predictor.
// Optional gshare indexing is enabled by defining LIEAT_BPU_GSHARE_EN.
package lieat_ifu_bpubht_pkg;

  localparam int BPU_XLEN_DEF  = 32;
  localparam int BHT_DEPTH_DEF = 32;
  localparam int CNT_W_DEF     = 2;
  localparam int GHR_W_DEF     = 5;

  typedef enum logic [0:0] {
    BPU_STATE_IDLE  = 1'b0,
    BPU_STATE_CLEAR = 1'b1
  } bpu_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lieat_ifu_bpubht_if.sv
// Lookup, training, clear and statistics bundle of the BHT predictor.
// Fetch/EXU side uses master, the predictor uses slave.
interface lieat_ifu_bpubht_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5,
  parameter int GHR_W = 5
);

  logic [XLEN-1:0]  prdt_pc;
  logic             prdt_bxx;
  logic             prdt_taken;
  logic [IDX_W-1:0] prdt_index;
  logic [GHR_W-1:0] prdt_ghr;
  logic             upd_en;
  logic [IDX_W-1:0] upd_index;
  logic             upd_result;
  logic             upd_mispred;
  logic [GHR_W-1:0] upd_ghr;
  logic             clr_req;
  logic             clr_busy;
  logic [31:0]      stat_lookups;
  logic [31:0]      stat_mispreds;

  modport master (
    output prdt_pc, prdt_bxx,
    output upd_en, upd_index, upd_result,
    output upd_mispred, upd_ghr, clr_req,
    input  prdt_taken, prdt_index, prdt_ghr,
    input  clr_busy, stat_lookups, stat_mispreds
  );

  modport slave (
    input  prdt_pc, prdt_bxx,
    input  upd_en, upd_index, upd_result,
    input  upd_mispred, upd_ghr, clr_req,
    output prdt_taken, prdt_index, prdt_ghr,
    output clr_busy, stat_lookups, stat_mispreds
  );

endinterface

// File: rtl/lieat_ifu_bpucnt.sv
// One saturating counter cell of the BHT.
// Resets and re-initialises to weakly-not-taken.
module lieat_ifu_bpucnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             init,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] INIT =
    CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= INIT;
    end else if (init) begin
      cnt <= INIT;
    end else if (inc) begin
      if (cnt != MAX) cnt <= cnt + ONE;
    end else if (dec) begin
      if (cnt != '0) cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/lieat_ifu_bpubht.sv
// Parametrised BHT direction predictor with clear sweep and stats.
// Define LIEAT_BPU_GSHARE_EN for gshare indexing with speculative GHR.
module lieat_ifu_bpubht
  import lieat_ifu_bpubht_pkg::*;
#(
  parameter int XLEN      = BPU_XLEN_DEF,
  parameter int BHT_DEPTH = BHT_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GHR_W     = GHR_W_DEF
) (
  input logic               clk,
  input logic               rstn,
  lieat_ifu_bpubht_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BHT_DEPTH - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  bpu_state_e       state;
  bpu_state_e       state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic             idle;
  logic             clearing;
  logic             upd_act;
  logic             look_act;
  logic             mis_act;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] idx;
  logic [GHR_W-1:0] ghr_cur;
  logic [CNT_W-1:0] cnt [BHT_DEPTH];
  logic [31:0]      lookups;
  logic [31:0]      mispreds;
  logic             unused_ok;

  assign idle     = (state == BPU_STATE_IDLE);
  assign clearing = ~idle;
  assign pc_idx   = bus.prdt_pc[IDX_W+1:2];
  assign upd_act  = bus.upd_en & idle;
  assign look_act = bus.prdt_bxx & idle;
  assign mis_act  = upd_act & bus.upd_mispred;

  assign unused_ok = ^{bus.prdt_pc, bus.upd_ghr};

`ifdef LIEAT_BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // mispredict recovery overrides the speculative shift
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr <= '0;
    end else if (clearing) begin
      ghr <= '0;
    end else if (mis_act) begin
      ghr <= GHR_W'({bus.upd_ghr, bus.upd_result});
    end else if (look_act) begin
      ghr <= GHR_W'({ghr, bus.prdt_taken});
    end
  end

  assign ghr_cur = ghr;
  assign idx     = pc_idx ^ IDX_W'(ghr);
`else
  assign ghr_cur = '0;
  assign idx     = pc_idx;
`endif

  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_cell
    logic hit;
    logic wipe;

    assign hit  = upd_act &&
                  (bus.upd_index == IDX_W'(i));
    assign wipe = clearing && (ptr == IDX_W'(i));

    lieat_ifu_bpucnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .init (wipe),
      .inc  (hit & bus.upd_result),
      .dec  (hit & ~bus.upd_result),
      .cnt  (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BPU_STATE_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      BPU_STATE_IDLE: begin
        if (bus.clr_req) begin
          state_nxt = BPU_STATE_CLEAR;
          ptr_nxt   = '0;
        end
      end
      BPU_STATE_CLEAR: begin
        ptr_nxt = ptr + ONE;
        if (ptr == LAST) state_nxt = BPU_STATE_IDLE;
      end
      default: state_nxt = BPU_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lookups  <= '0;
      mispreds <= '0;
    end else begin
      if (look_act) lookups <= sat_inc32(lookups);
      if (mis_act) mispreds <= sat_inc32(mispreds);
    end
  end

  assign bus.prdt_taken    = idle & cnt[idx][CNT_W-1];
  assign bus.prdt_index    = idx;
  assign bus.prdt_ghr      = clearing ? '0 : ghr_cur;
  assign bus.clr_busy      = clearing;
  assign bus.stat_lookups  = lookups;
  assign bus.stat_mispreds = mispreds;

endmodule

// File: doc/lieat_ifu_bpubht.md
Name: lieat_ifu_bpubht

Overview:
Parametrised branch-history-table predictor for the IFU, the successor of the fixed 32-entry, 2-bit bxx predictor. Depth and counter width are configurable. The block adds a sequential table-clear sweep with a busy handshake, mispredict statistics counters and an optional gshare index mode with speculative global history and recovery. It sits between the IFU decode and AGU: it is looked up with the fetch PC and trained by the EXU bxx callback.

Parameters:
XLEN, 32, address width
BHT_DEPTH, 32, number of entries; power of two, >=4
CNT_W, 2, saturating counter width; >=1
GHR_W, 5, global history width; 1..log2(BHT_DEPTH)
IDX_W (localparam), log2(BHT_DEPTH), index width

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
prdt_pc  in  XLEN  fetch PC
prdt_bxx  in  1  current inst is a conditional branch (lookup qualifier)
prdt_taken  out  1  predicted direction, combinational from table
prdt_index  out  IDX_W  index used; carried down the pipe for callback
prdt_ghr  out  GHR_W  GHR snapshot before this lookup; carried down the pipe
upd_en  in  1  bxx callback valid
upd_index  in  IDX_W  index from prdt_index
upd_result  in  1  actual direction
upd_mispred  in  1  prediction was wrong
upd_ghr  in  GHR_W  snapshot from prdt_ghr
clr_req  in  1  start table clear (pulse)
clr_busy  out  1  clear sweep in progress
stat_lookups  out  32  count of qualified lookups
stat_mispreds  out  32  count of mispredict callbacks

Behaviour:
- Reset (async, rstn=0): every counter = weakly-not-taken = 2^(CNT_W-1)-1; GHR=0; FSM=IDLE; clr_busy=0; stats=0. Resulting outputs: prdt_taken=0, prdt_ghr=0.
- Index: prdt_index = prdt_pc[IDX_W+1:2] (gshare variant below).
- prdt_taken = MSB of the indexed counter. Lookup has zero latency.
- Training on upd_en: counter[upd_index] increments if upd_result=1, decrements if 0; saturates at 2^CNT_W-1 and at 0. Written at the clock edge.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update value. No bypass.
- Multiple updates are serialised by the pipeline; one per cycle max.
- FSM IDLE -> CLEAR on clr_req while IDLE. clr_req is ignored while in CLEAR.
- In CLEAR: a pointer walks 0..BHT_DEPTH-1, one entry per cycle, writing the weakly-not-taken value. Return to IDLE after the last entry. clr_busy=1 for exactly BHT_DEPTH cycles.
- During CLEAR: prdt_taken forced 0, upd_en dropped, GHR forced 0.
- If rstn falls mid-sweep: immediate reset state, sweep abandoned.
- Stats: stat_lookups increments on prdt_bxx while IDLE. stat_mispreds increments on upd_en & upd_mispred while IDLE. Both saturate at 0xFFFF_FFFF and do not wrap.
- Without gshare, the GHR is never updated and prdt_ghr reads 0.

Optional Feature:
LIEAT_BPU_GSHARE_EN
- Defined:
  - Index = pc[IDX_W+1:2] XOR zero-extended GHR.
  - On prdt_bxx in IDLE, GHR <= {GHR[GHR_W-2:0], prdt_taken} (speculative).
  - On upd_en & upd_mispred, GHR <= {upd_ghr[GHR_W-2:0], upd_result}. Recovery has priority over a same-cycle speculative shift.
  - prdt_ghr = GHR before the shift.
- Undefined:
  - GHR register not instantiated; prdt_ghr=0; upd_ghr ignored.
  - Index is PC bits only, i.e. bimodal behaviour identical to the fixed 32-entry predictor when BHT_DEPTH=32, CNT_W=2.

Decomposition:
- lieat_defines.v gains:
  - `BPU_STATE_IDLE / `BPU_STATE_CLEAR encodings
  - default values for BHT_DEPTH / CNT_W / GHR_W
- One sub-module: lieat_ifu_bpucnt, a single CNT_W saturating counter cell with inc/dec/load-init inputs, instantiated BHT_DEPTH times via generate.
- Index hashing, FSM and stats stay in the top.

Test Plan:
- Reset -> prdt_taken=0 for all 32 indices, stat_* = 0, clr_busy=0.
- Three upd_en result=1 on index 5 (CNT_W=2) -> counter 1->2->3->3 (saturated); prdt_taken=1 for pc=0x14. Then two result=0 -> counter 1, prdt_taken=0.
- Lookup pc=0x14 and update index 5 result=1 in same cycle (counter=1) -> prdt_taken=0 this cycle, 1 next cycle.
- Train all entries taken, pulse clr_req -> clr_busy high exactly 32 cycles; upd_en during sweep has no effect; a second clr_req at cycle 10 is ignored; afterwards all prdt_taken=0.
- rstn low at sweep cycle 7 -> clr_busy=0 immediately; all counters weakly-not-taken after release.
- GSHARE_EN, GHR_W=5:
  - Four predicted-taken lookups -> prdt_ghr=5'b01111.
  - Then mispredict update with upd_ghr=5'b00011, result=0 -> GHR=5'b00110.
  - Stat mispreds=1.
